// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Steps the select lines of an 8:1 mux through channels 0..7. On each
//   channel it waits SETTLE cycles and then samples the mux output Z. The
//   eight samples are packed into a byte and presented with a one-cycle
//   done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   start      scan request, only looked at while idle
//   abort      cancel the scan in progress, no done is produced
//   cont       continuous mode, looked at in DONE to restart the scan
//   Z          mux output
//   S2,S1,S0   registered mux select, S2 is the MSB
//   busy       high in SETTLE and SAMPLE
//   done       one-cycle pulse while in DONE
//   data       captured byte, data[i] = Z sampled on channel i
//   valid      sticky, set by the first completed scan after reset
//
// state  | meaning
// IDLE   | waiting for start, select holds its last value
// SETTLE | select stable, counting settle cycles
// SAMPLE | capture Z into shadow bit sel, then next channel or DONE
// DONE   | done pulse, data already updated; restart if cont

module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic       Z,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic       done,
  output logic [7:0] data,
  output logic       valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] sel;
  logic [3:0] cnt;
  logic [7:0] shd;
  logic [7:0] shd_next;

  // shadow with the current channel's sample merged in; data is loaded from
  // this on the SAMPLE->DONE edge so it is visible together with done
  always_comb begin
    shd_next      = shd;
    shd_next[sel] = Z;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 3'd0;
      cnt   <= 4'd0;
      shd   <= 8'h00;
      data  <= 8'h00;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state <= ST_SETTLE;
            sel   <= 3'd0;
            cnt   <= 4'd0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            sel   <= 3'd0;
            shd   <= 8'h00;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == CNT_LAST) state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
            sel   <= 3'd0;
            shd   <= 8'h00;
          end else begin
            shd <= shd_next;
            if (sel == 3'd7) begin
              state <= ST_DONE;
              data  <= shd_next;
              valid <= 1'b1;
            end else begin
              sel   <= sel + 3'd1;
              cnt   <= 4'd0;
              state <= ST_SETTLE;
            end
          end
        end
        default: begin
          // DONE: the pulse itself always completes; abort only blocks restart
          if (abort) begin
            state <= ST_IDLE;
            sel   <= 3'd0;
            shd   <= 8'h00;
          end else if (cont) begin
            state <= ST_SETTLE;
            sel   <= 3'd0;
            cnt   <= 4'd0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign {S2, S1, S0} = sel;
  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cont;
  logic       Z;
  logic       S2, S1, S0;
  logic       busy, done, valid;
  logic [7:0] data;
  logic [7:0] chan;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .Z(Z),
    .S2(S2), .S1(S1), .S0(S0), .busy(busy), .done(done), .data(data),
    .valid(valid)
  );

  always #5 clk = ~clk;

  // behavioural 8:1 mux feeding Z
  assign Z = chan[{S2, S1, S0}];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // start a scan (start high for edge E0), optionally re-pulse start during
  // cycle restart_c, then watch 28 cycles
  task automatic run_scan(input int restart_c, output int done_c, output int n_done,
                          output int sel_err, output logic busy_after,
                          output logic [7:0] data_at_done);
    done_c = 0; n_done = 0; sel_err = 0; busy_after = 1'b1; data_at_done = 8'hxx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      if (c <= 24 && {S2, S1, S0} != 3'((c - 1) / 3)) sel_err++;
      if (c == 25 && {S2, S1, S0} != 3'd7) sel_err++;
      if (done) begin
        n_done++;
        if (done_c == 0) begin done_c = c; data_at_done = data; end
      end
      if (c == 26) busy_after = busy;
      if (c == restart_c) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] chan;
    int         restart_c;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[11];

  int         dc, nd, se;
  logic       ba;
  logic [7:0] dd;
  int         done_pos[3];
  int         k;

  initial begin
    tbl[0]  = '{8'h01, 0, 8'h01};
    tbl[1]  = '{8'h02, 0, 8'h02};
    tbl[2]  = '{8'h04, 0, 8'h04};
    tbl[3]  = '{8'h08, 0, 8'h08};
    tbl[4]  = '{8'h10, 0, 8'h10};
    tbl[5]  = '{8'h20, 0, 8'h20};
    tbl[6]  = '{8'h40, 0, 8'h40};
    tbl[7]  = '{8'h80, 0, 8'h80};
    tbl[8]  = '{8'h81, 5, 8'h81};
    tbl[9]  = '{8'h3C, 0, 8'h3C};
    tbl[10] = '{8'h00, 0, 8'h00};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; chan = 8'h00;
    #2;
    chk("rst_sel",   {29'd0, S2, S1, S0}, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_data",  data, 8'h00);
    chk("rst_valid", valid, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      chan = tbl[i].chan;
      run_scan(tbl[i].restart_c, dc, nd, se, ba, dd);
      chk($sformatf("v%0d_done_cycle", i), dc, 25);
      chk($sformatf("v%0d_done_count", i), nd, 1);
      chk($sformatf("v%0d_data", i), dd, tbl[i].exp);
      chk($sformatf("v%0d_valid", i), valid, 1);
      chk($sformatf("v%0d_sel_steps", i), se, 0);
      chk($sformatf("v%0d_busy_after", i), ba, 0);
    end

    // start and abort together: abort wins, stays idle
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);

    // continuous mode, three back-to-back scans of 0x55
    chan = 8'h55; cont = 1'b1; k = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        if (k < 3) done_pos[k] = c;
        k++;
        chk($sformatf("cont_data_%0d", k), data, 8'h55);
        if (k == 3) cont = 1'b0;
      end
      if (c == 26 || c == 51) chk($sformatf("cont_nogap_c%0d", c), busy, 1);
      if (c == 76) chk("cont_stop_busy", busy, 0);
    end
    chk("cont_done_count", k, 3);
    chk("cont_done0", done_pos[0], 25);
    chk("cont_done1", done_pos[1], 50);
    chk("cont_done2", done_pos[2], 75);

    // abort mid-scan at cycle 10 with all inputs 1
    chan = 8'hFF; k = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) k++;
      if (c == 10) abort = 1'b1;
      if (c == 11) begin
        chk("abort_busy", busy, 0);
        chk("abort_sel", {29'd0, S2, S1, S0}, 0);
        abort = 1'b0;
      end
    end
    chk("abort_no_done", k, 0);
    chk("abort_data", data, 8'h55);
    chk("abort_valid", valid, 1);

    // abort while in DONE with cont: pulse completes, restart suppressed
    chan = 8'h0F; cont = 1'b1; k = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        k++;
        chk("done_abort_data", data, 8'h0F);
        abort = 1'b1;
      end
      if (c == 26) begin
        chk("done_abort_busy", busy, 0);
        chk("done_abort_sel", {29'd0, S2, S1, S0}, 0);
        abort = 1'b0; cont = 1'b0;
      end
    end
    chk("done_abort_count", k, 1);

    // asynchronous reset mid-scan at cycle 12
    chan = 8'hAA;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel",   {29'd0, S2, S1, S0}, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_done",  done, 0);
    chk("arst_data",  data, 8'h00);
    chk("arst_valid", valid, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("arst_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
